pipelined_datapath: RTL and testbench
=====================================

// Module: pipelined_datapath
// PURPOSE
// Five-stage (IF/ID/EX/MEM/WB) MIPS datapath, successor to the single-cycle datapath, driven by the existing combinational control unit.
// Holds PC, register file, ALU, sign-extend and the pipeline registers, plus hazard logic (forwarding, load-use interlock, branch/jump flush).
// Talks to instruction memory in IF and data memory in MEM; the control unit decodes the ID-stage instruction.
// PARAMETERS
// DATA_W     32   datapath/PC width (>=32; instruction width fixed at 32)
// RESET_PC   0    PC value loaded on reset
// FORWARD_EN 1    1: EX forwarding from MEM/WB; 0: interlock-only (stall until writeback)
// PORTS
// CLK          in   1       clock, all state updates on rising edge
// reset        in   1       synchronous, active-high
// Instr_F      in   32      instruction memory data for PC_F
// PC_F         out  DATA_W  fetch address
// Op_D         out  6       Instr_D[31:26] to control unit
// Funct_D      out  6       Instr_D[5:0] to control unit
// RegWrite_D   in   1       control for ID-stage instruction
// MemtoReg_D   in   1       control, ID stage
// MemWrite_D   in   1       control, ID stage
// ALUSrc_D     in   1       control, ID stage
// RegDst_D     in   1       control, ID stage
// Branch_D     in   1       beq, ID stage
// Jump_D       in   1       j, ID stage
// ALUControl_D in   3       ALU op, ID stage
// ReadData_M   in   DATA_W  data memory read data (combinational on ALUOut_M)
// ALUOut_M     out  DATA_W  data memory address
// WriteData_M  out  DATA_W  data memory write data
// MemWrite_M   out  1       data memory write enable
// Stall_F      out  1       PC and IF/ID held this cycle (debug/perf)
// Flush_E      out  1       bubble inserted into ID/EX this cycle
// BEHAVIOUR
// - Reset: PC_F=RESET_PC; all pipeline regs cleared to NOP (instr 0, all control 0); regfile all 0; all outputs 0 except PC_F.
// - Reset mid-operation discards all in-flight instructions; no writes (reg or mem) in the reset cycle or the cycle after.
// - Latency: instruction retires (reg write) 4 cycles after fetch with no hazards; throughput 1 instr/cycle.
// - Regfile: write on CLK edge in WB; same-cycle ID read of the WB register returns the new value (internal bypass).
// - $0 reads 0; writes to $0 ignored; $0 never a forwarding/interlock match.
// - WriteReg = RegDst ? Instr[15:11] : Instr[20:16]; SignImm = Instr[15] replicated to DATA_W.
// - Forward (FORWARD_EN=1), per EX operand Rs_E/Rt_E: MEM match (RegWrite_M) -> ALUOut_M; else WB match -> Result_W; else ID/EX value. MEM beats WB.
// - Forwarded Rt value also feeds WriteData_E (store data).
// - Load-use: MemtoReg_E and (Rs_D==Rt_E or Rt_D==Rt_E), Rt_E!=0 -> stall PC, IF/ID one cycle, bubble ID/EX.
// - FORWARD_EN=0: stall while Rs_D/Rt_D matches nonzero WriteReg_E (RegWrite_E) or WriteReg_M (RegWrite_M).
// - Branch resolved in EX: taken = Branch_E & Zero_E; target = PCPlus4_E + (SignImm_E<<2) mod 2^DATA_W; flush IF/ID and ID/EX (2-cycle penalty).
// - Jump resolved in ID: target {PCPlus4_D[DATA_W-1:28], Instr_D[25:0], 2'b00}; flush IF/ID (1-cycle penalty).
// - Priority: taken branch > stall > jump > PC+4. Taken branch cancels a concurrent stall and a concurrent ID jump.
// - PC+4 wraps modulo 2^DATA_W with no fault.
// - Stall_F high exactly in stall cycles; Flush_E high on stall bubbles and taken-branch flushes.
// TESTING
// - add $1,$2,$3 ; sub $4,$1,$5 ($2=5,$3=7,$5=2) -> $4=10, no stall; FORWARD_EN=0 -> 2 stall cycles, same result.
// - lw $1,0($0) (mem[0]=9) ; add $2,$1,$1 -> exactly 1 Stall_F cycle, $2=18.
// - beq $0,$0,+3 then 2 filler addi -> fillers never write; next fetch at PC_beq+16; not-taken beq -> no flush.
// - j 0x40 at PC 0x8 -> one bubble, PC_F=0x100 next-but-one cycle; j behind taken beq -> beq target wins.
// - addi $0,$0,5 ; add $1,$0,$0 -> $1=0, $0 stays 0.
// - assert reset with 3 stores in flight -> MemWrite_M=0, PC_F=RESET_PC next cycle, all regs 0.

Source files
------------

// File: rtl/pipelined_datapath.sv
// Five-stage MIPS pipeline (IF/ID/EX/MEM/WB) with EX forwarding, load-use interlock
// and branch/jump flushing. Control decode of the ID instruction is done externally.
module pipelined_datapath #(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter bit                FORWARD_EN = 1'b1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [31:0]       Instr_F,
  output logic [DATA_W-1:0] PC_F,
  output logic [5:0]        Op_D,
  output logic [5:0]        Funct_D,
  input  logic              RegWrite_D,
  input  logic              MemtoReg_D,
  input  logic              MemWrite_D,
  input  logic              ALUSrc_D,
  input  logic              RegDst_D,
  input  logic              Branch_D,
  input  logic              Jump_D,
  input  logic [2:0]        ALUControl_D,
  input  logic [DATA_W-1:0] ReadData_M,
  output logic [DATA_W-1:0] ALUOut_M,
  output logic [DATA_W-1:0] WriteData_M,
  output logic              MemWrite_M,
  output logic              Stall_F,
  output logic              Flush_E
);

  logic [DATA_W-1:0] pc_plus4_f;
  logic [31:0]       instr_d;
  logic [DATA_W-1:0] pc_plus4_d, rd1_d, rd2_d, sign_imm_d, jump_target_d;
  logic [4:0]        rs_d, rt_d, rd_d;
  logic [DATA_W-1:0] regs [32];

  logic              reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, branch_e;
  logic [2:0]        alu_control_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e;
  logic [4:0]        rs_e, rt_e, rd_e, write_reg_e;
  logic [DATA_W-1:0] src_a_e, src_b_e, write_data_e, alu_result_e, branch_target_e;
  logic              zero_e, pc_src_e;

  logic              reg_write_m, mem_to_reg_m, mem_write_m;
  logic [DATA_W-1:0] alu_out_m, write_data_m;
  logic [4:0]        write_reg_m;

  logic              reg_write_w, mem_to_reg_w, we_w;
  logic [DATA_W-1:0] read_data_w, alu_out_w, result_w;
  logic [4:0]        write_reg_w;

  logic              lw_stall, dep_stall, stall, flush_e;

  assign pc_plus4_f    = PC_F + DATA_W'(4);
  assign rs_d          = instr_d[25:21];
  assign rt_d          = instr_d[20:16];
  assign rd_d          = instr_d[15:11];
  assign sign_imm_d    = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
  assign jump_target_d = {pc_plus4_d[DATA_W-1:28], instr_d[25:0], 2'b00};
  assign Op_D          = instr_d[31:26];
  assign Funct_D       = instr_d[5:0];

  assign result_w = mem_to_reg_w ? read_data_w : alu_out_w;
  assign we_w     = reg_write_w && (write_reg_w != 5'd0) && !reset;

  // Register file reads see the value being written back this same cycle.
  always_comb begin
    rd1_d = regs[rs_d];
    rd2_d = regs[rt_d];
    if (we_w && write_reg_w == rs_d) rd1_d = result_w;
    if (we_w && write_reg_w == rt_d) rd2_d = result_w;
    if (rs_d == 5'd0) rd1_d = '0;
    if (rt_d == 5'd0) rd2_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we_w) begin
      regs[write_reg_w] <= result_w;
    end
  end

  // MEM result has priority over WB because it is the younger producer.
  always_comb begin
    src_a_e      = rd1_e;
    write_data_e = rd2_e;
    if (FORWARD_EN) begin
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == rs_e) src_a_e = alu_out_m;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == rs_e) src_a_e = result_w;
      if (reg_write_m && write_reg_m != 5'd0 && write_reg_m == rt_e) write_data_e = alu_out_m;
      else if (reg_write_w && write_reg_w != 5'd0 && write_reg_w == rt_e) write_data_e = result_w;
    end
  end

  assign src_b_e     = alu_src_e ? sign_imm_e : write_data_e;
  assign write_reg_e = reg_dst_e ? rd_e : rt_e;

  always_comb begin
    alu_result_e = '0;
    case (alu_control_e)
      3'b000:  alu_result_e = src_a_e & src_b_e;
      3'b001:  alu_result_e = src_a_e | src_b_e;
      3'b010:  alu_result_e = src_a_e + src_b_e;
      3'b100:  alu_result_e = src_a_e & ~src_b_e;
      3'b101:  alu_result_e = src_a_e | ~src_b_e;
      3'b110:  alu_result_e = src_a_e - src_b_e;
      3'b111:  alu_result_e = {{(DATA_W-1){1'b0}}, $signed(src_a_e) < $signed(src_b_e)};
      default: alu_result_e = '0;
    endcase
  end

  assign zero_e          = (alu_result_e == '0);
  assign pc_src_e        = branch_e && zero_e;
  assign branch_target_e = pc_plus4_e + (sign_imm_e << 2);

  // A taken branch squashes whatever the stall was protecting, so it cancels the stall.
  assign lw_stall  = mem_to_reg_e && (rt_e != 5'd0) && (rs_d == rt_e || rt_d == rt_e);
  assign dep_stall = !FORWARD_EN &&
    ((reg_write_e && write_reg_e != 5'd0 && (rs_d == write_reg_e || rt_d == write_reg_e)) ||
     (reg_write_m && write_reg_m != 5'd0 && (rs_d == write_reg_m || rt_d == write_reg_m)));
  assign stall     = (lw_stall || dep_stall) && !pc_src_e;
  assign flush_e   = stall || pc_src_e;

  assign Stall_F     = stall && !reset;
  assign Flush_E     = flush_e && !reset;
  assign MemWrite_M  = mem_write_m && !reset;
  assign ALUOut_M    = alu_out_m;
  assign WriteData_M = write_data_m;

  always_ff @(posedge CLK) begin
    if (reset) PC_F <= RESET_PC;
    else if (pc_src_e) PC_F <= branch_target_e;
    else if (!stall) PC_F <= Jump_D ? jump_target_d : pc_plus4_f;
  end

  always_ff @(posedge CLK) begin
    if (reset || pc_src_e || (!stall && Jump_D)) begin
      instr_d    <= '0;
      pc_plus4_d <= '0;
    end else if (!stall) begin
      instr_d    <= Instr_F;
      pc_plus4_d <= pc_plus4_f;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || flush_e) begin
      reg_write_e <= 1'b0; mem_to_reg_e <= 1'b0; mem_write_e <= 1'b0;
      alu_src_e   <= 1'b0; reg_dst_e    <= 1'b0; branch_e    <= 1'b0;
      alu_control_e <= '0;
      rd1_e <= '0; rd2_e <= '0; sign_imm_e <= '0; pc_plus4_e <= '0;
      rs_e  <= '0; rt_e  <= '0; rd_e <= '0;
    end else begin
      reg_write_e <= RegWrite_D; mem_to_reg_e <= MemtoReg_D; mem_write_e <= MemWrite_D;
      alu_src_e   <= ALUSrc_D;   reg_dst_e    <= RegDst_D;   branch_e    <= Branch_D;
      alu_control_e <= ALUControl_D;
      rd1_e <= rd1_d; rd2_e <= rd2_d; sign_imm_e <= sign_imm_d; pc_plus4_e <= pc_plus4_d;
      rs_e  <= rs_d;  rt_e  <= rt_d;  rd_e <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      reg_write_m <= 1'b0; mem_to_reg_m <= 1'b0; mem_write_m <= 1'b0;
      alu_out_m   <= '0;   write_data_m <= '0;   write_reg_m <= '0;
      reg_write_w <= 1'b0; mem_to_reg_w <= 1'b0;
      read_data_w <= '0;   alu_out_w    <= '0;   write_reg_w <= '0;
    end else begin
      reg_write_m <= reg_write_e;  mem_to_reg_m <= mem_to_reg_e; mem_write_m <= mem_write_e;
      alu_out_m   <= alu_result_e; write_data_m <= write_data_e; write_reg_m <= write_reg_e;
      reg_write_w <= reg_write_m;  mem_to_reg_w <= mem_to_reg_m;
      read_data_w <= ReadData_M;   alu_out_w    <= alu_out_m;    write_reg_w <= write_reg_m;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed bench for pipelined_datapath: two instances (forwarding on / interlock-only)
// run the same program; results are observed through stores into bench data memories.
module tb_pipelined_datapath;

  typedef struct packed {
    logic       reg_write, mem_to_reg, mem_write, alu_src, reg_dst, branch, jump;
    logic [2:0] alu_control;
  } ctrl_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic [31:0] init_w0 = 32'd0;
  logic [31:0] imem [0:127];
  logic [31:0] dmem_a [0:63];
  logic [31:0] dmem_b [0:63];

  logic [31:0] instr_f_a, pc_f_a, read_data_m_a, alu_out_m_a, write_data_m_a;
  logic [31:0] instr_f_b, pc_f_b, read_data_m_b, alu_out_m_b, write_data_m_b;
  logic [5:0]  op_d_a, funct_d_a, op_d_b, funct_d_b;
  logic        mem_write_m_a, stall_f_a, flush_e_a, mem_write_m_b, stall_f_b, flush_e_b;
  ctrl_t       ctrl_a, ctrl_b;

  int total = 0;
  int bad = 0;
  int hcnt, stall_a, stall_b, flush_a, flush_b;
  logic [31:0] pc_hist [0:255];
  logic        flush_hist [0:255];
  logic        stall_hist [0:255];

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      6'h00: begin
        c.reg_write = 1'b1; c.reg_dst = 1'b1;
        case (funct)
          6'h22:   c.alu_control = 3'b110;
          6'h24:   c.alu_control = 3'b000;
          6'h25:   c.alu_control = 3'b001;
          6'h2a:   c.alu_control = 3'b111;
          default: c.alu_control = 3'b010;
        endcase
      end
      6'h23: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.alu_control = 3'b010; end
      6'h2b: begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_control = 3'b010; end
      6'h04: begin c.branch = 1'b1; c.alu_control = 3'b110; end
      6'h08: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_control = 3'b010; end
      6'h02: c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] r_op(input logic [5:0] funct, input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_op(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  assign ctrl_a        = decode(op_d_a, funct_d_a);
  assign ctrl_b        = decode(op_d_b, funct_d_b);
  assign instr_f_a     = imem[pc_f_a[8:2]];
  assign instr_f_b     = imem[pc_f_b[8:2]];
  assign read_data_m_a = dmem_a[alu_out_m_a[7:2]];
  assign read_data_m_b = dmem_b[alu_out_m_b[7:2]];

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        dmem_a[i] <= (i == 0) ? init_w0 : (32'hdead_0000 | 32'(i));
        dmem_b[i] <= (i == 0) ? init_w0 : (32'hdead_0000 | 32'(i));
      end
    end else begin
      if (mem_write_m_a) dmem_a[alu_out_m_a[7:2]] <= write_data_m_a;
      if (mem_write_m_b) dmem_b[alu_out_m_b[7:2]] <= write_data_m_b;
    end
  end

  pipelined_datapath #(.DATA_W(32), .RESET_PC(32'h0), .FORWARD_EN(1'b1)) dut_a (
    .CLK(CLK), .reset(reset), .Instr_F(instr_f_a), .PC_F(pc_f_a),
    .Op_D(op_d_a), .Funct_D(funct_d_a),
    .RegWrite_D(ctrl_a.reg_write), .MemtoReg_D(ctrl_a.mem_to_reg), .MemWrite_D(ctrl_a.mem_write),
    .ALUSrc_D(ctrl_a.alu_src), .RegDst_D(ctrl_a.reg_dst), .Branch_D(ctrl_a.branch),
    .Jump_D(ctrl_a.jump), .ALUControl_D(ctrl_a.alu_control),
    .ReadData_M(read_data_m_a), .ALUOut_M(alu_out_m_a), .WriteData_M(write_data_m_a),
    .MemWrite_M(mem_write_m_a), .Stall_F(stall_f_a), .Flush_E(flush_e_a)
  );

  pipelined_datapath #(.DATA_W(32), .RESET_PC(32'h0), .FORWARD_EN(1'b0)) dut_b (
    .CLK(CLK), .reset(reset), .Instr_F(instr_f_b), .PC_F(pc_f_b),
    .Op_D(op_d_b), .Funct_D(funct_d_b),
    .RegWrite_D(ctrl_b.reg_write), .MemtoReg_D(ctrl_b.mem_to_reg), .MemWrite_D(ctrl_b.mem_write),
    .ALUSrc_D(ctrl_b.alu_src), .RegDst_D(ctrl_b.reg_dst), .Branch_D(ctrl_b.branch),
    .Jump_D(ctrl_b.jump), .ALUControl_D(ctrl_b.alu_control),
    .ReadData_M(read_data_m_b), .ALUOut_M(alu_out_m_b), .WriteData_M(write_data_m_b),
    .MemWrite_M(mem_write_m_b), .Stall_F(stall_f_b), .Flush_E(flush_e_b)
  );

  task automatic clear_imem();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
  endtask

  // Two reset cycles, memories re-initialised; returns #1 after the releasing negedge.
  task automatic start(input logic [31:0] w0);
    init_w0  = w0;
    reset    = 1'b1;
    mem_init = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    reset    = 1'b0;
    mem_init = 1'b0;
    hcnt = 0; stall_a = 0; stall_b = 0; flush_a = 0; flush_b = 0;
    #1;
  endtask

  // hist[k] holds the state after k rising edges since reset release.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      pc_hist[hcnt]    = pc_f_a;
      flush_hist[hcnt] = flush_e_a;
      stall_hist[hcnt] = stall_f_a;
      stall_a += int'(stall_f_a); stall_b += int'(stall_f_b);
      flush_a += int'(flush_e_a); flush_b += int'(flush_e_b);
      hcnt++;
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    clear_imem();
    reset = 1'b1; mem_init = 1'b1;
    @(negedge CLK); @(negedge CLK); #1;
    total++; if (pc_f_a !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_f_a, 32'h0); end
    total++; if (mem_write_m_a !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b exp=0", mem_write_m_a); end
    total++; if (alu_out_m_a !== 32'h0) begin bad++; $display("FAIL reset_aluout got=%h exp=0", alu_out_m_a); end
    total++; if (write_data_m_a !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", write_data_m_a); end
    total++; if ({op_d_a, funct_d_a} !== 12'h0) begin bad++; $display("FAIL reset_opfunct got=%h exp=0", {op_d_a, funct_d_a}); end
    total++; if ({stall_f_a, flush_e_a} !== 2'b00) begin bad++; $display("FAIL reset_hazard got=%b exp=00", {stall_f_a, flush_e_a}); end
    start(32'h0);
    run_cycles(3);
    total++; if (pc_hist[0] !== 32'h0) begin bad++; $display("FAIL pc_seq0 got=%h exp=0", pc_hist[0]); end
    total++; if (pc_hist[2] !== 32'h8) begin bad++; $display("FAIL pc_seq2 got=%h exp=8", pc_hist[2]); end
  endtask

  task automatic test_forward();
    clear_imem();
    imem[0]  = i_op(6'h08, 5'd0, 5'd2, 16'd5);
    imem[1]  = i_op(6'h08, 5'd0, 5'd3, 16'd7);
    imem[2]  = i_op(6'h08, 5'd0, 5'd5, 16'd2);
    imem[5]  = r_op(6'h20, 5'd1, 5'd2, 5'd3);
    imem[6]  = r_op(6'h22, 5'd4, 5'd1, 5'd5);
    imem[9]  = i_op(6'h2b, 5'd0, 5'd4, 16'd0);
    imem[10] = i_op(6'h2b, 5'd0, 5'd1, 16'd4);
    start(32'h0);
    run_cycles(30);
    total++; if (dmem_a[0] !== 32'd10) begin bad++; $display("FAIL fwd_a_r4 got=%0d exp=10", dmem_a[0]); end
    total++; if (dmem_a[1] !== 32'd12) begin bad++; $display("FAIL fwd_a_r1 got=%0d exp=12", dmem_a[1]); end
    total++; if (dmem_b[0] !== 32'd10) begin bad++; $display("FAIL fwd_b_r4 got=%0d exp=10", dmem_b[0]); end
    total++; if (stall_a !== 0) begin bad++; $display("FAIL fwd_a_stalls got=%0d exp=0", stall_a); end
    total++; if (stall_b !== 2) begin bad++; $display("FAIL fwd_b_stalls got=%0d exp=2", stall_b); end
    total++; if (flush_b !== 2) begin bad++; $display("FAIL fwd_b_bubbles got=%0d exp=2", flush_b); end
  endtask

  task automatic test_load_use();
    clear_imem();
    imem[0] = i_op(6'h23, 5'd0, 5'd1, 16'd0);
    imem[1] = r_op(6'h20, 5'd2, 5'd1, 5'd1);
    imem[4] = i_op(6'h2b, 5'd0, 5'd2, 16'd8);
    start(32'd9);
    run_cycles(25);
    total++; if (dmem_a[2] !== 32'd18) begin bad++; $display("FAIL lu_a_r2 got=%0d exp=18", dmem_a[2]); end
    total++; if (dmem_b[2] !== 32'd18) begin bad++; $display("FAIL lu_b_r2 got=%0d exp=18", dmem_b[2]); end
    total++; if (stall_a !== 1) begin bad++; $display("FAIL lu_a_stalls got=%0d exp=1", stall_a); end
    total++; if (stall_b !== 2) begin bad++; $display("FAIL lu_b_stalls got=%0d exp=2", stall_b); end
    total++; if ({stall_hist[2], flush_hist[2]} !== 2'b11) begin bad++; $display("FAIL lu_stall_cycle got=%b exp=11", {stall_hist[2], flush_hist[2]}); end
    total++; if (pc_hist[3] !== 32'h8) begin bad++; $display("FAIL lu_pc_hold got=%h exp=8", pc_hist[3]); end
  endtask

  task automatic test_branch();
    clear_imem();
    imem[0]  = i_op(6'h08, 5'd0, 5'd1, 16'd1);
    imem[4]  = i_op(6'h04, 5'd0, 5'd0, 16'd3);
    imem[5]  = i_op(6'h08, 5'd0, 5'd6, 16'd11);
    imem[6]  = i_op(6'h08, 5'd0, 5'd7, 16'd12);
    imem[7]  = i_op(6'h08, 5'd0, 5'd8, 16'd13);
    imem[8]  = i_op(6'h08, 5'd0, 5'd9, 16'd14);
    imem[9]  = i_op(6'h04, 5'd1, 5'd0, 16'd5);
    imem[10] = i_op(6'h08, 5'd0, 5'd10, 16'd15);
    imem[13] = i_op(6'h2b, 5'd0, 5'd6, 16'd0);
    imem[14] = i_op(6'h2b, 5'd0, 5'd7, 16'd4);
    imem[15] = i_op(6'h2b, 5'd0, 5'd8, 16'd8);
    imem[16] = i_op(6'h2b, 5'd0, 5'd9, 16'd12);
    imem[17] = i_op(6'h2b, 5'd0, 5'd10, 16'd16);
    start(32'h0);
    run_cycles(35);
    total++; if ({dmem_a[0], dmem_a[1], dmem_a[2]} !== 96'h0) begin bad++; $display("FAIL br_fillers got=%h_%h_%h exp=0_0_0", dmem_a[0], dmem_a[1], dmem_a[2]); end
    total++; if (dmem_a[3] !== 32'd14) begin bad++; $display("FAIL br_target_exec got=%0d exp=14", dmem_a[3]); end
    total++; if (dmem_a[4] !== 32'd15) begin bad++; $display("FAIL br_nt_exec got=%0d exp=15", dmem_a[4]); end
    total++; if (pc_hist[6] !== 32'h18) begin bad++; $display("FAIL br_pc_ex got=%h exp=18", pc_hist[6]); end
    total++; if (pc_hist[7] !== 32'h20) begin bad++; $display("FAIL br_pc_target got=%h exp=20", pc_hist[7]); end
    total++; if (flush_hist[6] !== 1'b1) begin bad++; $display("FAIL br_flush_cycle got=%b exp=1", flush_hist[6]); end
    total++; if (flush_a !== 1) begin bad++; $display("FAIL br_flush_count got=%0d exp=1", flush_a); end
  endtask

  task automatic test_jump();
    clear_imem();
    imem[0]  = i_op(6'h08, 5'd0, 5'd1, 16'd1);
    imem[2]  = j_op(26'h40);
    imem[3]  = i_op(6'h08, 5'd0, 5'd2, 16'd22);
    imem[64] = i_op(6'h08, 5'd0, 5'd3, 16'd33);
    imem[67] = i_op(6'h2b, 5'd0, 5'd2, 16'd0);
    imem[68] = i_op(6'h2b, 5'd0, 5'd3, 16'd4);
    start(32'h5);
    run_cycles(20);
    total++; if (pc_hist[3] !== 32'hc) begin bad++; $display("FAIL j_pc_id got=%h exp=c", pc_hist[3]); end
    total++; if (pc_hist[4] !== 32'h100) begin bad++; $display("FAIL j_pc_target got=%h exp=100", pc_hist[4]); end
    total++; if (pc_hist[5] !== 32'h104) begin bad++; $display("FAIL j_pc_after got=%h exp=104", pc_hist[5]); end
    total++; if (dmem_a[0] !== 32'd0) begin bad++; $display("FAIL j_filler got=%0d exp=0", dmem_a[0]); end
    total++; if (dmem_a[1] !== 32'd33) begin bad++; $display("FAIL j_target_exec got=%0d exp=33", dmem_a[1]); end
    total++; if (flush_a !== 0) begin bad++; $display("FAIL j_flush_e got=%0d exp=0", flush_a); end
  endtask

  task automatic test_branch_over_jump();
    clear_imem();
    imem[0] = i_op(6'h04, 5'd0, 5'd0, 16'd3);
    imem[1] = j_op(26'h40);
    imem[2] = i_op(6'h08, 5'd0, 5'd4, 16'd66);
    imem[4] = i_op(6'h08, 5'd0, 5'd4, 16'd44);
    imem[7] = i_op(6'h2b, 5'd0, 5'd4, 16'd8);
    start(32'h0);
    run_cycles(20);
    total++; if (pc_hist[2] !== 32'h8) begin bad++; $display("FAIL bj_pc_ex got=%h exp=8", pc_hist[2]); end
    total++; if (pc_hist[3] !== 32'h10) begin bad++; $display("FAIL bj_branch_wins got=%h exp=10", pc_hist[3]); end
    total++; if (dmem_a[2] !== 32'd44) begin bad++; $display("FAIL bj_result got=%0d exp=44", dmem_a[2]); end
    total++; if (flush_a !== 1) begin bad++; $display("FAIL bj_flush_count got=%0d exp=1", flush_a); end
  endtask

  task automatic test_zero_reg();
    clear_imem();
    imem[0] = i_op(6'h08, 5'd0, 5'd0, 16'd5);
    imem[1] = r_op(6'h20, 5'd1, 5'd0, 5'd0);
    imem[4] = i_op(6'h2b, 5'd0, 5'd1, 16'd0);
    imem[5] = i_op(6'h2b, 5'd0, 5'd0, 16'd4);
    start(32'h7);
    run_cycles(20);
    total++; if (dmem_a[0] !== 32'd0) begin bad++; $display("FAIL z_a_r1 got=%0d exp=0", dmem_a[0]); end
    total++; if (dmem_a[1] !== 32'd0) begin bad++; $display("FAIL z_a_r0 got=%0d exp=0", dmem_a[1]); end
    total++; if (dmem_b[0] !== 32'd0) begin bad++; $display("FAIL z_b_r1 got=%0d exp=0", dmem_b[0]); end
    total++; if (stall_b !== 0) begin bad++; $display("FAIL z_b_stalls got=%0d exp=0", stall_b); end
  endtask

  task automatic test_back_to_back();
    clear_imem();
    imem[0]  = i_op(6'h08, 5'd0, 5'd6, 16'd77);
    imem[1]  = i_op(6'h2b, 5'd0, 5'd6, 16'd20);
    imem[2]  = i_op(6'h08, 5'd0, 5'd7, 16'd88);
    imem[4]  = i_op(6'h2b, 5'd0, 5'd7, 16'd24);
    imem[5]  = i_op(6'h08, 5'd0, 5'd8, 16'd1);
    imem[6]  = i_op(6'h08, 5'd0, 5'd8, 16'd2);
    imem[7]  = r_op(6'h20, 5'd9, 5'd8, 5'd8);
    imem[8]  = i_op(6'h2b, 5'd0, 5'd9, 16'd28);
    imem[9]  = r_op(6'h22, 5'd10, 5'd9, 5'd6);
    imem[10] = r_op(6'h2a, 5'd11, 5'd10, 5'd0);
    imem[11] = i_op(6'h2b, 5'd0, 5'd10, 16'd32);
    imem[12] = i_op(6'h2b, 5'd0, 5'd11, 16'd36);
    imem[13] = i_op(6'h08, 5'd0, 5'd12, 16'hfffd);
    imem[14] = i_op(6'h2b, 5'd0, 5'd12, 16'd40);
    start(32'h0);
    run_cycles(45);
    total++; if (dmem_a[5] !== 32'd77) begin bad++; $display("FAIL b2b_store_fwd_mem got=%0d exp=77", dmem_a[5]); end
    total++; if (dmem_a[6] !== 32'd88) begin bad++; $display("FAIL b2b_store_fwd_wb got=%0d exp=88", dmem_a[6]); end
    total++; if (dmem_a[7] !== 32'd4) begin bad++; $display("FAIL b2b_mem_beats_wb got=%0d exp=4", dmem_a[7]); end
    total++; if (dmem_a[8] !== 32'hffff_ffb7) begin bad++; $display("FAIL b2b_sub got=%h exp=ffffffb7", dmem_a[8]); end
    total++; if (dmem_a[9] !== 32'd1) begin bad++; $display("FAIL b2b_slt got=%0d exp=1", dmem_a[9]); end
    total++; if (dmem_a[10] !== 32'hffff_fffd) begin bad++; $display("FAIL b2b_signext got=%h exp=fffffffd", dmem_a[10]); end
    total++; if (dmem_b[7] !== 32'd4) begin bad++; $display("FAIL b2b_b_add got=%0d exp=4", dmem_b[7]); end
    total++; if (dmem_b[8] !== 32'hffff_ffb7) begin bad++; $display("FAIL b2b_b_sub got=%h exp=ffffffb7", dmem_b[8]); end
  endtask

  task automatic test_reset_mid();
    clear_imem();
    imem[0] = i_op(6'h08, 5'd0, 5'd1, 16'd5);
    imem[4] = i_op(6'h2b, 5'd0, 5'd1, 16'd0);
    imem[5] = i_op(6'h2b, 5'd0, 5'd1, 16'd4);
    imem[6] = i_op(6'h2b, 5'd0, 5'd1, 16'd8);
    imem[7] = i_op(6'h2b, 5'd0, 5'd1, 16'd12);
    start(32'h0);
    run_cycles(7);
    total++; if (mem_write_m_a !== 1'b1) begin bad++; $display("FAIL rm_store_in_mem got=%b exp=1", mem_write_m_a); end
    reset = 1'b1;
    #1;
    total++; if (mem_write_m_a !== 1'b0) begin bad++; $display("FAIL rm_memwrite_gated got=%b exp=0", mem_write_m_a); end
    clear_imem();
    imem[4] = i_op(6'h2b, 5'd0, 5'd1, 16'd16);
    @(negedge CLK); #1;
    total++; if (pc_f_a !== 32'h0) begin bad++; $display("FAIL rm_pc got=%h exp=0", pc_f_a); end
    total++; if (mem_write_m_a !== 1'b0) begin bad++; $display("FAIL rm_memwrite_after got=%b exp=0", mem_write_m_a); end
    reset = 1'b0;
    hcnt = 0;
    #1;
    run_cycles(15);
    total++; if (dmem_a[0] !== 32'h0) begin bad++; $display("FAIL rm_w0 got=%h exp=0", dmem_a[0]); end
    total++; if ({dmem_a[1], dmem_a[2], dmem_a[3]} !== {32'hdead_0001, 32'hdead_0002, 32'hdead_0003}) begin
      bad++; $display("FAIL rm_no_writes got=%h_%h_%h exp=dead0001_dead0002_dead0003", dmem_a[1], dmem_a[2], dmem_a[3]);
    end
    total++; if (dmem_a[4] !== 32'h0) begin bad++; $display("FAIL rm_regs_cleared got=%h exp=0", dmem_a[4]); end
  endtask

  initial begin
    clear_imem();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_jump();
    test_branch_over_jump();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
